// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg
// Shared types and helpers for the button conditioner slice.
//   btn_state_t : states of the shared strobe FSM
//   cnt_width   : bit width needed to hold values 0..n inclusive
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    LOCK
  } btn_state_t;

  // Counters are sized to reach their terminal parameter value without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// debounce_sync
// Brings one raw, bouncy push-button into the clock domain and debounces it.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   btn_i   : raw button pin, asynchronous
//   level_o : debounced button state, 1 = pressed
module debounce_sync
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);

  localparam int            CntW     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic          Released = BTN_ACTIVE_LOW;

  logic            sync1_q;
  logic            sync2_q;
  logic            pressed;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            level_q;
  logic            level_d;

  // Two-flop synchroniser. The flops reset to whatever the pin reads when the
  // button is not pressed, so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= Released;
      sync2_q <= Released;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Polarity is normalised only after the second flop so the synchroniser
  // chain stays a pure flop-to-flop path.
  assign pressed = sync2_q ^ BTN_ACTIVE_LOW;

  // Debounce next-state: count consecutive cycles where the synchronised value
  // disagrees with the accepted level. The counter flips the level on its last
  // step instead of incrementing past it, so it never wraps.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (pressed != level_q) begin
      if (cnt_q >= CntLast) begin
        level_d = pressed;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
// Turns the raw increment/decrement buttons into clean single-cycle duty-step
// strobes for the PWM stage, with auto-repeat while a button is held.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   btn_inc   : raw increment button
//   btn_dec   : raw decrement button
//   inc_pulse : single-cycle increment strobe
//   dec_pulse : single-cycle decrement strobe
//   inc_level : debounced increment button state
//   dec_level : debounced decrement button state
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_inc,
  input  logic btn_dec,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  localparam int              MaxCycles = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int              CntW      = cnt_width(MaxCycles);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RepLast   = CntW'(REPEAT_CYCLES - 1);

  logic            incLevel;
  logic            decLevel;
  logic            incRise;
  logic            decRise;
  logic            ownerLevel;

  btn_state_t      state_q;
  logic [CntW-1:0] cnt_q;
  logic            ownerInc_q;
  logic            incPrev_q;
  logic            decPrev_q;
  logic            incPulse_q;
  logic            decPulse_q;

  debounce_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debounce_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_inc),
    .level_o (incLevel)
  );

  debounce_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debounce_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_dec),
    .level_o (decLevel)
  );

  assign incRise    = incLevel & ~incPrev_q;
  assign decRise    = decLevel & ~decPrev_q;
  assign ownerLevel = ownerInc_q ? incLevel : decLevel;

  // Shared strobe FSM. Only a press that starts from IDLE on its own earns a
  // strobe; any moment with both buttons held parks the FSM in LOCK until both
  // are released, so a leftover held button can never resume stepping. The
  // HOLD/REPEAT counter stops at its terminal value and clears, so it cannot
  // wrap into a false strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ownerInc_q <= 1'b0;
      incPrev_q  <= 1'b0;
      decPrev_q  <= 1'b0;
      incPulse_q <= 1'b0;
      decPulse_q <= 1'b0;
    end else begin
      incPrev_q  <= incLevel;
      decPrev_q  <= decLevel;
      incPulse_q <= 1'b0;
      decPulse_q <= 1'b0;
      if (incLevel && decLevel) begin
        state_q <= LOCK;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (incRise ^ decRise) begin
              state_q    <= HOLD;
              cnt_q      <= '0;
              ownerInc_q <= incRise;
              incPulse_q <= incRise;
              decPulse_q <= decRise;
            end
          end
          HOLD: begin
            if (!ownerLevel) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q >= HoldLast) begin
              state_q    <= REPEAT;
              cnt_q      <= '0;
              incPulse_q <= ownerInc_q;
              decPulse_q <= ~ownerInc_q;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          REPEAT: begin
            if (!ownerLevel) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q >= RepLast) begin
              cnt_q      <= '0;
              incPulse_q <= ownerInc_q;
              decPulse_q <= ~ownerInc_q;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          LOCK: begin
            if (!incLevel && !decLevel) begin
              state_q <= IDLE;
            end
            cnt_q <= '0;
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign inc_pulse = incPulse_q;
  assign dec_pulse = decPulse_q;
  assign inc_level = incLevel;
  assign dec_level = decLevel;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=10, REPEAT_CYCLES=5, active-high buttons.
// Timing reference: a raw change driven at the falling edge where cycleCnt==P
// shows a level change at cycleCnt P+6 and a first strobe at cycleCnt P+7.
module tb_button_conditioner;

  localparam int FirstLat = 7;
  localparam int LevelLat = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_inc = 1'b0;
  logic btn_dec = 1'b0;
  logic inc_pulse;
  logic dec_pulse;
  logic inc_level;
  logic dec_level;

  typedef struct {
    int cyc;
    bit isInc;
  } exp_t;

  exp_t expQ[$];
  int   cycleCnt   = 0;
  int   checkCount = 0;
  int   passCount  = 0;
  bit   monitorEn  = 1'b0;

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (5),
    .BTN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse),
    .inc_level (inc_level),
    .dec_level (dec_level)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Posedge counter used as the time base for every expectation.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic applyStimulus(input logic inc, input logic dec);
    btn_inc = inc;
    btn_dec = dec;
  endtask

  task automatic waitUntil(input int cyc);
    while (cycleCnt < cyc) @(negedge clk);
  endtask

  task automatic pushPulse(input int cyc, input bit isInc);
    exp_t e;
    e.cyc   = cyc;
    e.isInc = isInc;
    expQ.push_back(e);
  endtask

  // Monitor: retires expectations that were never seen, and matches every
  // observed strobe against the head of the scoreboard (2 = inc, 1 = dec).
  always @(negedge clk) begin
    if (monitorEn) begin
      while (expQ.size() > 0 && expQ[0].cyc < cycleCnt) begin
        checkOutput("missed_pulse_cycle", cycleCnt, expQ[0].cyc);
        void'(expQ.pop_front());
      end
      if (inc_pulse || dec_pulse) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pulse", int'({inc_pulse, dec_pulse}), 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("pulse_cycle", cycleCnt, e.cyc);
          checkOutput("pulse_select", int'({inc_pulse, dec_pulse}), e.isInc ? 2 : 1);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int p;
    int e0;
    int r;
    int widths[10];
    widths = '{1, 2, 3, 1, 3, 2, 1, 2, 3, 2};

    applyStimulus(1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_inc_pulse", inc_pulse, 0);
    checkOutput("reset_dec_pulse", dec_pulse, 0);
    checkOutput("reset_inc_level", inc_level, 0);
    checkOutput("reset_dec_level", dec_level, 0);
    rst_n     = 1'b1;
    monitorEn = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press followed by an early release: one strobe only.
    p = cycleCnt;
    applyStimulus(1'b1, 1'b0);
    pushPulse(p + FirstLat, 1'b1);
    waitUntil(p + LevelLat - 1);
    checkOutput("clean_level_before", inc_level, 0);
    waitUntil(p + LevelLat);
    checkOutput("clean_level_after", inc_level, 1);
    waitUntil(p + FirstLat + 2);
    applyStimulus(1'b0, 1'b0);
    waitUntil(p + 14);
    checkOutput("early_release_level_held", inc_level, 1);
    waitUntil(p + 15);
    checkOutput("early_release_level_fall", inc_level, 0);
    waitUntil(p + 40);

    // Bounce: segments of 1-3 cycles never reach the debounce threshold.
    for (int s = 0; s < 10; s++) begin
      applyStimulus((s % 2) == 0, 1'b0);
      for (int c = 0; c < widths[s]; c++) begin
        @(negedge clk);
        checkOutput("bounce_inc_level", inc_level, 0);
      end
    end
    applyStimulus(1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("bounce_settle_inc_level", inc_level, 0);
    end
    waitUntil(cycleCnt + 10);

    // Auto-repeat on dec: strobes at offsets 0,10,15,...,40 from the first.
    p  = cycleCnt;
    e0 = p + FirstLat;
    applyStimulus(1'b0, 1'b1);
    pushPulse(e0, 1'b0);
    for (int off = 10; off <= 40; off += 5) pushPulse(e0 + off, 1'b0);
    waitUntil(p + LevelLat);
    checkOutput("repeat_dec_level", dec_level, 1);
    waitUntil(e0 + 36);
    applyStimulus(1'b0, 1'b0);
    waitUntil(e0 + 60);
    checkOutput("repeat_dec_level_released", dec_level, 0);

    // Both buttons: dec joins mid-HOLD, which locks out all further strobes.
    p  = cycleCnt;
    e0 = p + FirstLat;
    applyStimulus(1'b1, 1'b0);
    pushPulse(e0, 1'b1);
    waitUntil(e0 + 2);
    applyStimulus(1'b1, 1'b1);
    waitUntil(e0 + 8);
    checkOutput("both_dec_level", dec_level, 1);
    checkOutput("both_inc_level", inc_level, 1);
    waitUntil(e0 + 20);
    applyStimulus(1'b1, 1'b0);
    waitUntil(e0 + 40);
    checkOutput("lock_dec_released", dec_level, 0);
    checkOutput("lock_inc_still_held", inc_level, 1);
    applyStimulus(1'b0, 1'b0);
    waitUntil(e0 + 50);
    checkOutput("lock_inc_released", inc_level, 0);
    p = cycleCnt;
    applyStimulus(1'b0, 1'b1);
    pushPulse(p + FirstLat, 1'b0);
    waitUntil(p + FirstLat + 2);
    applyStimulus(1'b0, 1'b0);
    waitUntil(p + 30);

    // Simultaneous press goes straight to LOCK with no strobe.
    p = cycleCnt;
    applyStimulus(1'b1, 1'b1);
    waitUntil(p + LevelLat);
    checkOutput("simul_inc_level", inc_level, 1);
    checkOutput("simul_dec_level", dec_level, 1);
    waitUntil(p + 20);
    applyStimulus(1'b0, 1'b0);
    waitUntil(p + 35);

    // Reset in REPEAT while inc is held, then a fresh first strobe.
    p  = cycleCnt;
    e0 = p + FirstLat;
    applyStimulus(1'b1, 1'b0);
    pushPulse(e0, 1'b1);
    pushPulse(e0 + 10, 1'b1);
    waitUntil(e0 + 12);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_inc_level", inc_level, 0);
    checkOutput("midreset_inc_pulse", inc_pulse, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r = cycleCnt;
    pushPulse(r + FirstLat, 1'b1);
    waitUntil(r + LevelLat - 1);
    checkOutput("postreset_level_before", inc_level, 0);
    waitUntil(r + LevelLat);
    checkOutput("postreset_level_after", inc_level, 1);
    waitUntil(r + FirstLat + 2);
    applyStimulus(1'b0, 1'b0);
    waitUntil(r + 30);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
